// File: rtl/column_sequencer.sv
// Gamma-cycle sequencer for a spiking column: reset window, compute window, first-spike capture.
// Define COLUMN_SEQ_WTA_EN to report only the winner in spike_vector (winner-take-all inhibition).
module column_sequencer #(
  parameter int NUM_NEURONS = 4,
  parameter int RST_LEN     = 2,
  parameter int GAMMA_LEN   = 16
) (
  input  logic                           clk,
  input  logic                           grst,
  input  logic                           start,
  input  logic [$clog2(NUM_NEURONS)-1:0] num_neurons,
  input  logic [NUM_NEURONS-1:0]         neuron_spikes,
  output logic                           rstb,
  output logic                           busy,
  output logic                           done,
  output logic                           winner_valid,
  output logic [$clog2(NUM_NEURONS)-1:0] winner_id,
  output logic [$clog2(GAMMA_LEN)-1:0]   winner_time,
  output logic [NUM_NEURONS-1:0]         spike_vector,
  output logic [15:0]                    gamma_count
);

  localparam int ID_W = $clog2(NUM_NEURONS);
  localparam int TW   = $clog2(GAMMA_LEN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESET   = 2'd1,
    COMPUTE = 2'd2,
    REPORT  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        rst_cnt;
  logic [TW-1:0]     t_cnt;
  logic [NUM_NEURONS-1:0] en_mask;
  logic [NUM_NEURONS-1:0] masked;
  logic [ID_W-1:0]   first_idx;
  logic              new_winner;

  function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_NEURONS-1:0] v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (v[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RESET;
      RESET:   if (rst_cnt == 4'(RST_LEN - 1)) state_d = COMPUTE;
      COMPUTE: if (t_cnt == TW'(GAMMA_LEN - 1)) state_d = REPORT;
      REPORT:  state_d = start ? RESET : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // neurons 0..num_neurons are live; num_neurons is sampled every cycle
  always_comb begin
    en_mask = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      en_mask[i] = (ID_W'(i) <= num_neurons);
    end
  end

  assign masked     = neuron_spikes & en_mask;
  assign first_idx  = lowest_idx(masked);
  assign new_winner = (|masked) && !winner_valid;

  assign rstb = (state_q == COMPUTE);
  assign busy = (state_q != IDLE);
  assign done = (state_q == REPORT);

  always_ff @(posedge clk) begin
    if (grst) begin
      state_q     <= IDLE;
      rst_cnt     <= '0;
      t_cnt       <= '0;
      gamma_count <= '0;
    end else begin
      state_q <= state_d;
      rst_cnt <= (state_q == RESET && state_d == RESET) ? rst_cnt + 4'd1 : 4'd0;
      t_cnt   <= (state_q == COMPUTE && state_d == COMPUTE) ? t_cnt + 1'b1 : '0;
      if (state_q == REPORT) gamma_count <= gamma_count + 16'd1;
    end
  end

  // results clear on the edge into COMPUTE so the t=0 sample lands on a clean slate
  always_ff @(posedge clk) begin
    if (grst) begin
      winner_valid <= 1'b0;
      winner_id    <= '0;
      winner_time  <= '0;
      spike_vector <= '0;
    end else if (state_q == RESET && state_d == COMPUTE) begin
      winner_valid <= 1'b0;
      winner_id    <= '0;
      winner_time  <= '0;
      spike_vector <= '0;
    end else if (state_q == COMPUTE) begin
      if (new_winner) begin
        winner_valid <= 1'b1;
        winner_id    <= first_idx;
        winner_time  <= t_cnt;
      end
`ifdef COLUMN_SEQ_WTA_EN
      if (new_winner) spike_vector <= NUM_NEURONS'(1) << first_idx;
`else
      spike_vector <= spike_vector | masked;
`endif
    end
  end

endmodule

// File: tb/tb_column_sequencer.sv
// Directed bench for column_sequencer: gamma timing, first-spike capture, masking, abort.
module tb_column_sequencer;

  logic       clk;
  logic       grst;
  logic       start;
  logic [1:0] num_neurons;
  logic [3:0] neuron_spikes;
  logic       rstb, busy, done, winner_valid;
  logic [1:0] winner_id;
  logic [3:0] winner_time;
  logic [3:0] spike_vector;
  logic [15:0] gamma_count;

  int total = 0;
  int bad   = 0;

  logic [3:0] spk_tab [16];
  logic [1:0] nn_tab  [16];

  column_sequencer #(.NUM_NEURONS(4), .RST_LEN(2), .GAMMA_LEN(16)) dut (
    .clk(clk), .grst(grst), .start(start), .num_neurons(num_neurons),
    .neuron_spikes(neuron_spikes), .rstb(rstb), .busy(busy), .done(done),
    .winner_valid(winner_valid), .winner_id(winner_id), .winner_time(winner_time),
    .spike_vector(spike_vector), .gamma_count(gamma_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_tabs(input logic [1:0] nn);
    for (int i = 0; i < 16; i++) begin
      spk_tab[i] = 4'd0;
      nn_tab[i]  = nn;
    end
  endtask

  // Requests a gamma, plays the tables over t=0..15, and returns in the REPORT cycle.
  task automatic run_window(input logic keep_start, output bit ok);
    int n;
    ok = 1'b1;
    start = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!rstb && n < 40);
    if (!rstb) begin
      ok = 1'b0;
      return;
    end
    start = keep_start;
    for (int t = 0; t < 16; t++) begin
      neuron_spikes = spk_tab[t];
      num_neurons   = nn_tab[t];
      step();
    end
    neuron_spikes = 4'd0;
  endtask

  task automatic test_reset;
    grst = 1'b1; start = 1'b1; num_neurons = 2'd3; neuron_spikes = 4'hF;
    step();
    grst = 1'b0; start = 1'b0; neuron_spikes = 4'd0;
    total++;
    if ({rstb, busy, done, winner_valid, winner_id, winner_time, spike_vector, gamma_count} !== 30'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%0h want=0",
               {rstb, busy, done, winner_valid, winner_id, winner_time, spike_vector, gamma_count});
    end
  endtask

  task automatic test_back_to_back;
    int n;
    bit ok;
    step(); step();
    start = 1'b1;
    step();
    n = 0;
    while (!rstb && busy && n < 40) begin n++; step(); end
    total++;
    if (n !== 2) begin bad++; $display("FAIL rst_len got=%0d want=2", n); end
    n = 0;
    while (rstb && n < 40) begin n++; step(); end
    total++;
    if (n !== 16) begin bad++; $display("FAIL gamma_len got=%0d want=16", n); end
    total++;
    if ({done, rstb, busy, gamma_count} !== {1'b1, 1'b0, 1'b1, 16'd0}) begin
      bad++; $display("FAIL report1 got=%0h want=%0h", {done, rstb, busy, gamma_count}, {3'b101, 16'd0});
    end
    step();
    total++;
    if ({done, rstb, busy, gamma_count} !== {1'b0, 1'b0, 1'b1, 16'd1}) begin
      bad++; $display("FAIL b2b_reset got=%0h want=%0h", {done, rstb, busy, gamma_count}, {3'b001, 16'd1});
    end
    clear_tabs(2'd3);
    run_window(1'b1, ok);
    total++;
    if (!ok || done !== 1'b1) begin bad++; $display("FAIL report2 got=%0b want=1", done); end
    step();
    total++;
    if ({busy, gamma_count} !== {1'b1, 16'd2}) begin
      bad++; $display("FAIL count2 got=%0h want=%0h", {busy, gamma_count}, {1'b1, 16'd2});
    end
    // start dropped during RESET must not abort this gamma
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin n++; step(); end
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL no_abort got=%0b want=1", done); end
    step();
    total++;
    if ({busy, rstb, gamma_count} !== {1'b0, 1'b0, 16'd3}) begin
      bad++; $display("FAIL to_idle got=%0h want=%0h", {busy, rstb, gamma_count}, {2'b00, 16'd3});
    end
  endtask

  task automatic test_first_spike;
    bit ok;
    logic [3:0] exp_sv;
`ifdef COLUMN_SEQ_WTA_EN
    exp_sv = 4'b0010;
`else
    exp_sv = 4'b0011;
`endif
    clear_tabs(2'd2);
    spk_tab[3] = 4'b0010;
    spk_tab[5] = 4'b0001;
    spk_tab[1] = 4'b1000;
    run_window(1'b0, ok);
    total++;
    if (!ok || {done, winner_valid, winner_id, winner_time} !== {1'b1, 1'b1, 2'd1, 4'd3}) begin
      bad++; $display("FAIL first_spike got=%0h want=%0h",
                      {done, winner_valid, winner_id, winner_time}, {2'b11, 2'd1, 4'd3});
    end
    total++;
    if (spike_vector !== exp_sv) begin
      bad++; $display("FAIL first_spike_vec got=%0b want=%0b", spike_vector, exp_sv);
    end
    step();
    total++;
    if ({busy, winner_valid, winner_id, winner_time, spike_vector} !== {1'b0, 1'b1, 2'd1, 4'd3, exp_sv}) begin
      bad++; $display("FAIL hold_results got=%0h want=%0h",
                      {busy, winner_valid, winner_id, winner_time, spike_vector}, {2'b01, 2'd1, 4'd3, exp_sv});
    end
  endtask

  task automatic test_tie;
    bit ok;
    logic [3:0] exp_sv;
`ifdef COLUMN_SEQ_WTA_EN
    exp_sv = 4'b0001;
`else
    exp_sv = 4'b1101;
`endif
    clear_tabs(2'd3);
    spk_tab[0] = 4'b0101;
    spk_tab[9] = 4'b1000;
    run_window(1'b0, ok);
    total++;
    if (!ok || {winner_valid, winner_id, winner_time} !== {1'b1, 2'd0, 4'd0}) begin
      bad++; $display("FAIL tie got=%0h want=%0h", {winner_valid, winner_id, winner_time}, {1'b1, 6'd0});
    end
    total++;
    if (spike_vector !== exp_sv) begin
      bad++; $display("FAIL tie_vec got=%0b want=%0b", spike_vector, exp_sv);
    end
    step();
  endtask

  task automatic test_nn_change;
    bit ok;
    clear_tabs(2'd1);
    for (int i = 0; i < 4; i++) nn_tab[i] = 2'd0;
    spk_tab[2] = 4'b0010;
    spk_tab[4] = 4'b0010;
    run_window(1'b0, ok);
    total++;
    if (!ok || {winner_valid, winner_id, winner_time, spike_vector} !== {1'b1, 2'd1, 4'd4, 4'b0010}) begin
      bad++; $display("FAIL nn_change got=%0h want=%0h",
                      {winner_valid, winner_id, winner_time, spike_vector}, {1'b1, 2'd1, 4'd4, 4'b0010});
    end
    step();
  endtask

  task automatic test_no_spike;
    bit ok;
    clear_tabs(2'd3);
    run_window(1'b0, ok);
    total++;
    if (!ok || {done, winner_valid, winner_id, winner_time, spike_vector} !== {1'b1, 11'd0}) begin
      bad++; $display("FAIL no_spike got=%0h want=%0h",
                      {done, winner_valid, winner_id, winner_time, spike_vector}, {1'b1, 11'd0});
    end
    step();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL no_spike_idle got=%0b want=0", busy); end
  endtask

  task automatic test_abort;
    int n;
    bit seen_done;
    grst = 1'b1;
    step();
    grst = 1'b0;
    num_neurons = 2'd3;
    start = 1'b1;
    n = 0;
    do begin step(); n++; end while (!rstb && n < 40);
    total++;
    if (rstb !== 1'b1) begin bad++; $display("FAIL abort_enter got=%0b want=1", rstb); end
    for (int t = 0; t < 7; t++) begin
      neuron_spikes = (t == 2) ? 4'b0001 : 4'b0000;
      step();
    end
    grst = 1'b1;
    step();
    grst = 1'b0;
    start = 1'b0;
    total++;
    if ({rstb, busy, done, winner_valid, winner_id, winner_time, spike_vector, gamma_count} !== 30'd0) begin
      bad++; $display("FAIL abort_outputs got=%0h want=0",
                      {rstb, busy, done, winner_valid, winner_id, winner_time, spike_vector, gamma_count});
    end
    seen_done = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (done) seen_done = 1'b1;
      step();
    end
    total++;
    if ({seen_done, gamma_count} !== 17'd0) begin
      bad++; $display("FAIL abort_no_done got=%0h want=0", {seen_done, gamma_count});
    end
  endtask

  initial begin
    grst = 1'b1; start = 1'b0; num_neurons = 2'd3; neuron_spikes = 4'd0;
    test_reset();
    test_back_to_back();
    test_first_spike();
    test_tie();
    test_nn_change();
    test_no_spike();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
